// File: rtl/FPALL_pkg.sv
// FPALL_pkg: shared types for the FP add path alignment scheduler.
// Holds the FP format enum, the align request bundle, scheduler FSM states
// and the FP16 shift clamp helper.
package FPALL_pkg;

  typedef enum logic {
    FMT_FP32 = 1'b0,
    FMT_FP16 = 1'b1
  } fp_fmt_e;

  // Largest right shift applied to an FP16 lane.
  localparam int unsigned FP16_SHAMT_MAX = 15;

  // Tag field width carried in the request bundle; module tags up to this width.
  localparam int unsigned ALIGN_TAG_W = 16;

  typedef struct packed {
    fp_fmt_e                fmt;
    logic [22:0]            frac;
    logic [4:0]             shamt;
    logic [ALIGN_TAG_W-1:0] tag;
  } align_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_e;

  function automatic logic [4:0] fp16_clamp_shamt(input logic [4:0] sh);
    return (sh > 5'(FP16_SHAMT_MAX)) ? 5'(FP16_SHAMT_MAX) : sh;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// barrel_shifter: dual-lane right-shift alignment shifter.
// FP32: one 26-bit lane {x,2'b0} shifted by s[4:0].
// FP16: two independent 13-bit lanes, hi = R[25:13] by s[9:5], lo = R[12:0] by s[4:0].
// Sticky outputs OR every bit shifted out of the respective lane.
module barrel_shifter
  import FPALL_pkg::*;
(
  input  fp_fmt_e     fmt_i,
  input  logic [23:0] x_i,
  input  logic [9:0]  s_i,
  output logic [25:0] r_o,
  output logic        sticky_h_o,
  output logic        sticky_l_o
);

  logic [25:0] x_ext;
  logic [56:0] w32;
  logic [43:0] wh;
  logic [43:0] wl;

  assign x_ext = {x_i, 2'b00};

  // Shift into a wide window so the discarded bits remain visible for sticky.
  always_comb begin
    w32 = {x_ext, 31'b0} >> s_i[4:0];
    wh  = {x_ext[25:13], 31'b0} >> s_i[9:5];
    wl  = {x_ext[12:0], 31'b0} >> s_i[4:0];
    if (fmt_i == FMT_FP32) begin
      r_o        = w32[56:31];
      sticky_h_o = 1'b0;
      sticky_l_o = |w32[30:0];
    end else begin
      r_o        = {wh[43:31], wl[43:31]};
      sticky_h_o = |wh[30:0];
      sticky_l_o = |wl[30:0];
    end
  end

endmodule

// File: rtl/fp_align_scheduler.sv
// fp_align_scheduler: issue scheduler for the shared dual-lane alignment shifter.
// Pipeline HOLD (one FP16 slot) -> ISS (shifter operands) -> OUT (registered result).
// Two FP16 requests pack into one issue (first = hi lane, second = lo lane).
// Optional issue counters enabled by defining FP_ALIGN_PERF_EN.
module fp_align_scheduler
  import FPALL_pkg::*;
#(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned PAIR_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          in_fmt,
  input  logic [22:0]      in_frac,
  input  logic [4:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output fp_fmt_e          out_fmt,
  output logic [1:0]       out_lane_vld,
  output logic [25:0]      out_r,
  output logic             out_sticky_h,
  output logic             out_sticky_l,
  output logic [TAG_W-1:0] out_tag_h,
  output logic [TAG_W-1:0] out_tag_l,
  output logic [15:0]      perf_pair,
  output logic [15:0]      perf_single,
  output logic [15:0]      perf_fp32
);

  localparam int unsigned CNT_W = (PAIR_WAIT > 0) ? $clog2(PAIR_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(PAIR_WAIT);

  align_req_t       req;
  logic [TAG_W-1:0] req_tag;
  logic             in_is_fp32;

  sched_state_e     state_q, state_d;
  logic [6:0]       hold_frac_q;
  logic [4:0]       hold_sh_q;
  logic [TAG_W-1:0] hold_tag_q;
  logic             hold_load;
  logic             hold_full;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic             iss_vld_q;
  fp_fmt_e          iss_fmt_q, iss_fmt_d;
  logic [1:0]       iss_lane_q, iss_lane_d;
  logic [23:0]      iss_x_q, iss_x_d;
  logic [9:0]       iss_s_q, iss_s_d;
  logic [TAG_W-1:0] iss_tag_h_q, iss_tag_h_d;
  logic [TAG_W-1:0] iss_tag_l_q, iss_tag_l_d;
  logic             iss_load;

  logic             out_vld_q;
  fp_fmt_e          out_fmt_q;
  logic [1:0]       out_lane_q;
  logic [25:0]      out_r_q;
  logic             out_sh_q, out_sl_q;
  logic [TAG_W-1:0] out_tag_h_q, out_tag_l_q;

  logic [25:0]      sh_r;
  logic             sh_sticky_h, sh_sticky_l;

  logic             out_stall;
  logic             iss_adv;
  logic             iss_free;
  logic             accept;

  // Bundle the request ports.
  always_comb begin
    req.fmt   = in_fmt;
    req.frac  = in_frac;
    req.shamt = in_shamt;
    req.tag   = ALIGN_TAG_W'(in_tag);
  end

  assign req_tag    = TAG_W'(req.tag);
  assign in_is_fp32 = (req.fmt == FMT_FP32);
  assign hold_full  = (state_q == ST_HOLD);

  // Handshake: ISS moves on whenever OUT is empty or drained this cycle.
  always_comb begin
    out_stall = out_vld_q & ~out_ready;
    iss_adv   = iss_vld_q & ~out_stall;
    iss_free  = ~iss_vld_q | iss_adv;
    in_ready  = iss_free & ~(hold_full & in_is_fp32);
    accept    = in_valid & in_ready;
  end

  // Issue selection: pair, held singleton flush, FP32, direct FP16, or park in HOLD.
  // An FP32 arriving with HOLD occupied is refused so the older FP16 issues first.
  always_comb begin
    state_d     = state_q;
    hold_load   = 1'b0;
    iss_load    = 1'b0;
    iss_fmt_d   = FMT_FP16;
    iss_lane_d  = '0;
    iss_x_d     = '0;
    iss_s_d     = '0;
    iss_tag_h_d = '0;
    iss_tag_l_d = '0;
    if (hold_full) begin
      if (accept) begin
        iss_load    = 1'b1;
        iss_lane_d  = 2'b11;
        iss_x_d     = {hold_frac_q, 8'b0, req.frac[6:0], 2'b0};
        iss_s_d     = {hold_sh_q, fp16_clamp_shamt(req.shamt)};
        iss_tag_h_d = hold_tag_q;
        iss_tag_l_d = req_tag;
        state_d     = ST_IDLE;
      end else if (iss_free && ((wait_q == WAIT_MAX) || (in_valid && in_is_fp32))) begin
        iss_load    = 1'b1;
        iss_lane_d  = 2'b10;
        iss_x_d     = {hold_frac_q, 17'b0};
        iss_s_d     = {hold_sh_q, 5'b0};
        iss_tag_h_d = hold_tag_q;
        state_d     = ST_IDLE;
      end
    end else if (accept) begin
      if (in_is_fp32) begin
        iss_load    = 1'b1;
        iss_fmt_d   = FMT_FP32;
        iss_lane_d  = 2'b01;
        iss_x_d     = {req.frac, 1'b0};
        iss_s_d     = {5'b0, req.shamt};
        iss_tag_l_d = req_tag;
      end else if (PAIR_WAIT == 0) begin
        iss_load    = 1'b1;
        iss_lane_d  = 2'b10;
        iss_x_d     = {req.frac[6:0], 17'b0};
        iss_s_d     = {fp16_clamp_shamt(req.shamt), 5'b0};
        iss_tag_h_d = req_tag;
      end else begin
        hold_load = 1'b1;
        state_d   = ST_HOLD;
      end
    end
  end

  // Pairing wait counter: runs only in HOLD with ISS free and OUT not stalled.
  always_comb begin
    wait_d = wait_q;
    if (!hold_full || (state_d == ST_IDLE)) begin
      wait_d = '0;
    end else if (iss_free && !out_stall && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // FSM state, HOLD slot and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_frac_q <= '0;
      hold_sh_q   <= '0;
      hold_tag_q  <= '0;
      wait_q      <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (hold_load) begin
        hold_frac_q <= req.frac[6:0];
        hold_sh_q   <= fp16_clamp_shamt(req.shamt);
        hold_tag_q  <= req_tag;
      end
    end
  end

  // ISS register feeding the shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_q   <= 1'b0;
      iss_fmt_q   <= FMT_FP32;
      iss_lane_q  <= '0;
      iss_x_q     <= '0;
      iss_s_q     <= '0;
      iss_tag_h_q <= '0;
      iss_tag_l_q <= '0;
    end else if (iss_load) begin
      iss_vld_q   <= 1'b1;
      iss_fmt_q   <= iss_fmt_d;
      iss_lane_q  <= iss_lane_d;
      iss_x_q     <= iss_x_d;
      iss_s_q     <= iss_s_d;
      iss_tag_h_q <= iss_tag_h_d;
      iss_tag_l_q <= iss_tag_l_d;
    end else if (iss_adv) begin
      iss_vld_q <= 1'b0;
    end
  end

  barrel_shifter u_shifter (
    .fmt_i      (iss_fmt_q),
    .x_i        (iss_x_q),
    .s_i        (iss_s_q),
    .r_o        (sh_r),
    .sticky_h_o (sh_sticky_h),
    .sticky_l_o (sh_sticky_l)
  );

  // OUT register capturing the shifter result with its tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q   <= 1'b0;
      out_fmt_q   <= FMT_FP32;
      out_lane_q  <= '0;
      out_r_q     <= '0;
      out_sh_q    <= 1'b0;
      out_sl_q    <= 1'b0;
      out_tag_h_q <= '0;
      out_tag_l_q <= '0;
    end else if (iss_adv) begin
      out_vld_q   <= 1'b1;
      out_fmt_q   <= iss_fmt_q;
      out_lane_q  <= iss_lane_q;
      out_r_q     <= sh_r;
      out_sh_q    <= sh_sticky_h;
      out_sl_q    <= sh_sticky_l;
      out_tag_h_q <= iss_tag_h_q;
      out_tag_l_q <= iss_tag_l_q;
    end else if (out_ready) begin
      out_vld_q <= 1'b0;
    end
  end

  assign out_valid    = out_vld_q;
  assign out_fmt      = out_fmt_q;
  assign out_lane_vld = out_lane_q;
  assign out_r        = out_r_q;
  assign out_sticky_h = out_sh_q;
  assign out_sticky_l = out_sl_q;
  assign out_tag_h    = out_tag_h_q;
  assign out_tag_l    = out_tag_l_q;

`ifdef FP_ALIGN_PERF_EN
  logic [15:0] perf_pair_q, perf_single_q, perf_fp32_q;

  // Saturating counters of issues entering ISS, split by kind.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_pair_q   <= '0;
      perf_single_q <= '0;
      perf_fp32_q   <= '0;
    end else if (iss_load) begin
      if (iss_fmt_d == FMT_FP32) begin
        if (perf_fp32_q != '1) perf_fp32_q <= perf_fp32_q + 16'd1;
      end else if (iss_lane_d == 2'b11) begin
        if (perf_pair_q != '1) perf_pair_q <= perf_pair_q + 16'd1;
      end else begin
        if (perf_single_q != '1) perf_single_q <= perf_single_q + 16'd1;
      end
    end
  end

  assign perf_pair   = perf_pair_q;
  assign perf_single = perf_single_q;
  assign perf_fp32   = perf_fp32_q;
`else
  assign perf_pair   = '0;
  assign perf_single = '0;
  assign perf_fp32   = '0;
`endif

endmodule

// File: tb/tb_fp_align_scheduler.sv
// Scoreboard bench for fp_align_scheduler (TAG_W=4, PAIR_WAIT=4).
module tb_fp_align_scheduler;
  import FPALL_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  fp_fmt_e     in_fmt;
  logic [22:0] in_frac;
  logic [4:0]  in_shamt;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  fp_fmt_e     out_fmt;
  logic [1:0]  out_lane_vld;
  logic [25:0] out_r;
  logic        out_sticky_h;
  logic        out_sticky_l;
  logic [3:0]  out_tag_h;
  logic [3:0]  out_tag_l;
  logic [15:0] perf_pair, perf_single, perf_fp32;

  fp_align_scheduler #(.TAG_W(4), .PAIR_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_frac(in_frac), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt),
    .out_lane_vld(out_lane_vld), .out_r(out_r),
    .out_sticky_h(out_sticky_h), .out_sticky_l(out_sticky_l),
    .out_tag_h(out_tag_h), .out_tag_l(out_tag_l),
    .perf_pair(perf_pair), .perf_single(perf_single), .perf_fp32(perf_fp32)
  );

  always #5 clk = ~clk;

  typedef struct {
    fp_fmt_e     fmt;
    logic [1:0]  lane;
    logic [25:0] r;
    logic        sh;
    logic        sl;
    logic [3:0]  th;
    logic [3:0]  tl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic push(input fp_fmt_e f, input logic [1:0] ln, input logic [25:0] r,
                      input logic sh, input logic sl, input logic [3:0] th, input logic [3:0] tl);
    exp_t e;
    e.fmt = f; e.lane = ln; e.r = r; e.sh = sh; e.sl = sl; e.th = th; e.tl = tl;
    exp_q.push_back(e);
  endtask

  // Presents one request and returns once it has been accepted.
  task automatic send(input fp_fmt_e f, input logic [22:0] fr, input logic [4:0] sa,
                      input logic [3:0] tg, output int waited);
    bit done;
    in_valid = 1'b1; in_fmt = f; in_frac = fr; in_shamt = sa; in_tag = tg;
    waited = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        waited++;
        if (waited > 50) begin
          errors++;
          $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Cycles from now until out_valid rises (bounded).
  task automatic lat(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    int w;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_fmt = FMT_FP32; in_frac = '0; in_shamt = '0;
    in_tag = '0; out_ready = 1'b1;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL result_unexpected: got r=%h tag_l=%h, required no result", out_r, out_tag_l);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              if (out_fmt !== e.fmt || out_lane_vld !== e.lane || out_r !== e.r ||
                  out_sticky_h !== e.sh || out_sticky_l !== e.sl ||
                  out_tag_h !== e.th || out_tag_l !== e.tl) begin
                errors++;
                $display("FAIL result: got fmt=%0d lane=%b r=%h sh=%b sl=%b th=%h tl=%h, required fmt=%0d lane=%b r=%h sh=%b sl=%b th=%h tl=%h",
                         out_fmt, out_lane_vld, out_r, out_sticky_h, out_sticky_l, out_tag_h, out_tag_l,
                         e.fmt, e.lane, e.r, e.sh, e.sl, e.th, e.tl);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_lane_vld", out_lane_vld, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_perf", {perf_pair, perf_single}, 0);

    // FP32 single issue and N+2 latency
    send(FMT_FP32, 23'h400000, 5'd3, 4'd5, w);
    push(FMT_FP32, 2'b01, 26'h0400000, 1'b0, 1'b0, 4'd0, 4'd5);
    lat(n);
    chk("fp32_latency", n, 1);
    drain();

    // FP32 patterns back to back, including shift-out sticky cases
    send(FMT_FP32, 23'h7FFFFF, 5'd0, 4'd1, w);  push(FMT_FP32, 2'b01, 26'h3FFFFF8, 0, 0, 0, 1);
    send(FMT_FP32, 23'h000001, 5'd2, 4'd2, w);  push(FMT_FP32, 2'b01, 26'h0000002, 0, 0, 0, 2);
    send(FMT_FP32, 23'h000001, 5'd5, 4'd3, w);  push(FMT_FP32, 2'b01, 26'h0000000, 0, 1, 0, 3);
    send(FMT_FP32, 23'h7FFFFF, 5'd31, 4'd4, w); push(FMT_FP32, 2'b01, 26'h0000000, 0, 1, 0, 4);
    send(FMT_FP32, 23'h400001, 5'd4, 4'd6, w);  push(FMT_FP32, 2'b01, 26'h0200000, 0, 1, 0, 6);
    drain();

    // FP16 pair, latency from second acceptance
    send(FMT_FP16, 23'h40, 5'd2, 4'd1, w);
    send(FMT_FP16, 23'h40, 5'd1, 4'd2, w);
    push(FMT_FP16, 2'b11, 26'h0800200, 0, 0, 4'd1, 4'd2);
    lat(n);
    chk("pair_latency", n, 1);
    send(FMT_FP16, 23'h7F, 5'd31, 4'd3, w);
    send(FMT_FP16, 23'h01, 5'd0, 4'd4, w);
    push(FMT_FP16, 2'b11, 26'h0000010, 1, 0, 4'd3, 4'd4);
    send(FMT_FP16, 23'h55, 5'd3, 4'd5, w);
    send(FMT_FP16, 23'h03, 5'd5, 4'd6, w);
    push(FMT_FP16, 2'b11, 26'h0550001, 0, 1, 4'd5, 4'd6);
    drain();

    // Lone FP16 issues single-lane after the pairing wait
    send(FMT_FP16, 23'h01, 5'd1, 4'd7, w);
    push(FMT_FP16, 2'b10, 26'h0040000, 0, 0, 4'd7, 4'd0);
    lat(n);
    chk("lone_latency", n, 6);
    drain();

    // Held FP16 flushed by an FP32, FP32 refused for one cycle
    send(FMT_FP16, 23'h40, 5'd0, 4'd8, w);
    push(FMT_FP16, 2'b10, 26'h2000000, 0, 0, 4'd8, 4'd0);
    send(FMT_FP32, 23'h000100, 5'd1, 4'd9, w);
    push(FMT_FP32, 2'b01, 26'h0000400, 0, 0, 4'd0, 4'd9);
    chk("fp32_behind_hold_wait", w, 1);
    drain();

    // Output backpressure
    out_ready = 1'b0;
    send(FMT_FP32, 23'h000010, 5'd0, 4'd1, w); push(FMT_FP32, 2'b01, 26'h0000080, 0, 0, 0, 1);
    send(FMT_FP32, 23'h000020, 5'd0, 4'd2, w); push(FMT_FP32, 2'b01, 26'h0000100, 0, 0, 0, 2);
    in_valid = 1'b1; in_fmt = FMT_FP32; in_frac = 23'h000040; in_shamt = 5'd0; in_tag = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_r", out_r, 26'h0000080);
      chk("stall_tag_l", out_tag_l, 4'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(FMT_FP32, 23'h000040, 5'd0, 4'd3, w); push(FMT_FP32, 2'b01, 26'h0000200, 0, 0, 0, 3);
    send(FMT_FP32, 23'h000080, 5'd2, 4'd4, w); push(FMT_FP32, 2'b01, 26'h0000100, 0, 0, 0, 4);
    send(FMT_FP32, 23'h123456, 5'd8, 4'd5, w); push(FMT_FP32, 2'b01, 26'h00091A2, 0, 1, 0, 5);
    drain();

`ifdef FP_ALIGN_PERF_EN
    chk("perf_fp32", perf_fp32, 12);
    chk("perf_pair", perf_pair, 3);
    chk("perf_single", perf_single, 2);
`endif

    // Reset with OUT stalled and an FP16 held: nothing may emerge afterwards
    out_ready = 1'b0;
    send(FMT_FP32, 23'h000111, 5'd0, 4'd11, w);
    send(FMT_FP16, 23'h22, 5'd0, 4'd12, w);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_lane_vld", out_lane_vld, 0);
    chk("mid_rst_out_r", out_r, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_perf", {perf_pair, perf_single, perf_fp32}, 0);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(FMT_FP32, 23'h000003, 5'd1, 4'd10, w);
    push(FMT_FP32, 2'b01, 26'h000000C, 0, 0, 0, 4'd10);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
